key_event_encoder: RTL and testbench

KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

---
 rtl/key_event_encoder.sv | 108 ++++++++++
 tb/tb_key_event_encoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_encoder.sv
// Eight-line rising-edge event encoder: synchronizes level inputs, latches events
// into a pending vector and presents them one at a time in round-robin order.
module key_event_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i,
    input  logic       ready,
    input  logic       ovf_clr,
    output logic [2:0] o,
    output logic       valid,
    output logic [7:0] pend,
    output logic       ovf
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [7:0] r_s1;
    logic [7:0] r_s2;
    logic [7:0] r_s3;
    logic [7:0] r_pend;
    logic [2:0] r_o;
    logic [2:0] r_ptr;
    logic [0:0] r_state;
    logic       r_ovf;

    logic [7:0] w_rise;
    logic [7:0] w_clr;
    logic [7:0] w_pend_d;
    logic       w_drop;
    logic       w_accept;
    logic [2:0] w_sel;
    logic [2:0] w_idx;
    logic       w_found;

    assign w_rise   = r_s2 & ~r_s3;
    assign w_accept = (r_state == HOLD) && ready;

    always_comb begin
        w_clr = 8'h00;
        if (w_accept) begin
            w_clr[r_o] = 1'b1;
        end
    end

    // A rise on the bit being cleared re-arms it instead of counting as a drop.
    assign w_pend_d = (r_pend & ~w_clr) | w_rise;
    assign w_drop   = |(w_rise & r_pend & ~w_clr);

    // Round-robin pick: first set pending bit at or above ptr, wrapping 7 -> 0.
    always_comb begin
        w_sel   = r_ptr;
        w_idx   = r_ptr;
        w_found = 1'b0;
        for (int j = 0; j < 8; j++) begin
            w_idx = r_ptr + 3'(j);
            if (!w_found && r_pend[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= 8'h00;
            r_s2    <= 8'h00;
            r_s3    <= 8'h00;
            r_pend  <= 8'h00;
            r_o     <= 3'd0;
            r_ptr   <= 3'd0;
            r_state <= IDLE;
            r_ovf   <= 1'b0;
        end else begin
            r_s1   <= i;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_pend <= w_pend_d;

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (|r_pend) begin
                        r_o     <= w_sel;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        r_ptr   <= r_o + 3'd1;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign o     = r_o;
    assign valid = (r_state == HOLD);
    assign pend  = r_pend;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_key_event_encoder.sv
// Self-checking bench for key_event_encoder: directed scenarios plus random traffic,
// every cycle compared against an event-level reference model.
module tb_key_event_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] i;
    logic       ready;
    logic       ovf_clr;
    logic [2:0] o;
    logic       valid;
    logic [7:0] pend;
    logic       ovf;

    int n_vec;
    int n_err;
    int acc[$];

    // Reference model state
    bit m_s1[8];
    bit m_s2[8];
    bit m_s3[8];
    bit m_pend[8];
    int m_o;
    bit m_valid;
    int m_ptr;
    bit m_ovf;

    key_event_encoder dut (
        .clk     (clk),
        .rst     (rst),
        .i       (i),
        .ready   (ready),
        .ovf_clr (ovf_clr),
        .o       (o),
        .valid   (valid),
        .pend    (pend),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_pend_vec();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = m_pend[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_s1[k] = 0; m_s2[k] = 0; m_s3[k] = 0; m_pend[k] = 0;
        end
        m_o = 0; m_valid = 0; m_ptr = 0; m_ovf = 0;
    endtask

    // One clock edge of the event-level behaviour, from pre-edge state and inputs.
    task automatic model_edge(input logic [7:0] iv, input logic rd, input logic clr);
        bit nxt[8];
        bit drop;
        bit picked;
        bit rise;
        bit served;
        int idx;
        drop = 0;
        for (int k = 0; k < 8; k++) begin
            rise   = m_s2[k] && !m_s3[k];
            served = m_valid && rd && (m_o == k);
            if (rise && m_pend[k] && !served) drop = 1;
            nxt[k] = rise || (m_pend[k] && !served);
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (!m_valid) begin
            picked = 0;
            for (int j = 0; j < 8; j++) begin
                idx = (m_ptr + j) % 8;
                if (!picked && m_pend[idx]) begin
                    m_o = idx;
                    m_valid = 1;
                    picked = 1;
                end
            end
        end else if (rd) begin
            m_ptr = (m_o + 1) % 8;
            m_valid = 0;
        end
        for (int k = 0; k < 8; k++) begin
            m_pend[k] = nxt[k];
            m_s3[k] = m_s2[k];
            m_s2[k] = m_s1[k];
            m_s1[k] = iv[k];
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".o"}, {5'b0, o}, 8'(m_o));
        chk({tag, ".valid"}, {7'b0, valid}, {7'b0, m_valid});
        chk({tag, ".pend"}, pend, m_pend_vec());
        chk({tag, ".ovf"}, {7'b0, ovf}, {7'b0, m_ovf});
    endtask

    task automatic step();
        if (valid === 1'b1 && ready === 1'b1) acc.push_back(int'(o));
        model_edge(i, ready, ovf_clr);
        @(posedge clk);
        #1;
        check_all("cyc");
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int max, input string tag);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < max) begin
            step();
            n++;
        end
        chk({tag, ".valid_seen"}, {7'b0, valid}, 8'h01);
    endtask

    task automatic collect(input int n, input int max, input string tag);
        int c;
        acc.delete();
        c = 0;
        while (acc.size() < n && c < max) begin
            step();
            c++;
        end
        chk({tag, ".count"}, 8'(acc.size()), 8'(n));
    endtask

    initial begin
        logic [7:0] flip;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        i = 8'h00;
        ready = 1'b0;
        ovf_clr = 1'b0;
        #2;
        do_reset();

        // Single event: o=5 on E3, bubble on E4.
        i = 8'h20;
        ready = 1'b1;
        steps(3);
        chk("single.valid_e2", {7'b0, valid}, 8'h00);
        step();
        chk("single.valid_e3", {7'b0, valid}, 8'h01);
        chk("single.o_e3", {5'b0, o}, 8'd5);
        step();
        chk("single.valid_e4", {7'b0, valid}, 8'h00);
        chk("single.pend_e4", pend, 8'h00);

        // Simultaneous events from ptr=0: 0 then 7, twice.
        do_reset();
        i = 8'h81;
        ready = 1'b1;
        collect(2, 20, "simul1");
        if (acc.size() == 2) begin
            chk("simul1.first", 8'(acc[0]), 8'd0);
            chk("simul1.second", 8'(acc[1]), 8'd7);
        end
        i = 8'h00;
        steps(3);
        i = 8'h81;
        collect(2, 20, "simul2");
        if (acc.size() == 2) begin
            chk("simul2.first", 8'(acc[0]), 8'd0);
            chk("simul2.second", 8'(acc[1]), 8'd7);
        end

        // Round-robin wrap after serving 6.
        do_reset();
        i = 8'h40;
        ready = 1'b1;
        collect(1, 20, "rr.six");
        if (acc.size() == 1) chk("rr.six_code", 8'(acc[0]), 8'd6);
        i = 8'h00;
        steps(3);
        i = 8'h41;
        collect(1, 20, "rr.wrap0");
        if (acc.size() == 1) chk("rr.wrap0_code", 8'(acc[0]), 8'd0);
        collect(1, 20, "rr.again6");
        if (acc.size() == 1) chk("rr.again6_code", 8'(acc[0]), 8'd6);
        i = 8'h00;
        steps(3);
        i = 8'hC1;
        collect(1, 20, "rr.seven");
        if (acc.size() == 1) chk("rr.seven_code", 8'(acc[0]), 8'd7);

        // Backpressure plus overflow on line 2.
        do_reset();
        i = 8'h04;
        ready = 1'b0;
        wait_valid(10, "bp");
        chk("bp.o", {5'b0, o}, 8'd2);
        i = 8'h00;
        steps(3);
        i = 8'h04;
        steps(4);
        chk("bp.o_stable", {5'b0, o}, 8'd2);
        chk("bp.valid_stable", {7'b0, valid}, 8'h01);
        chk("bp.ovf_set", {7'b0, ovf}, 8'h01);
        chk("bp.pend2", {7'b0, pend[2]}, 8'h01);
        ready = 1'b1;
        step();
        chk("bp.pend2_clr", {7'b0, pend[2]}, 8'h00);
        chk("bp.valid_drop", {7'b0, valid}, 8'h00);
        chk("bp.ovf_sticky", {7'b0, ovf}, 8'h01);
        ready = 1'b0;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("bp.ovf_clr", {7'b0, ovf}, 8'h00);

        // Rise on line 3 coincides with acceptance of o=3.
        do_reset();
        i = 8'h08;
        ready = 1'b0;
        wait_valid(10, "coin");
        i = 8'h00;
        steps(3);
        i = 8'h08;
        steps(2);
        ready = 1'b1;
        step();
        chk("coin.pend3", {7'b0, pend[3]}, 8'h01);
        chk("coin.ovf", {7'b0, ovf}, 8'h00);
        chk("coin.bubble", {7'b0, valid}, 8'h00);
        ready = 1'b0;
        step();
        chk("coin.valid_again", {7'b0, valid}, 8'h01);
        chk("coin.o_again", {5'b0, o}, 8'd3);
        ready = 1'b1;
        step();

        // Asynchronous reset in HOLD, line 2 held high.
        do_reset();
        i = 8'h04;
        ready = 1'b0;
        wait_valid(10, "arst");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst.valid", {7'b0, valid}, 8'h00);
        chk("arst.o", {5'b0, o}, 8'h00);
        chk("arst.pend", pend, 8'h00);
        chk("arst.ovf", {7'b0, ovf}, 8'h00);
        #1;
        rst = 1'b0;
        wait_valid(10, "arst_after");
        chk("arst.o_after", {5'b0, o}, 8'd2);

        // Random traffic against the model.
        do_reset();
        i = 8'h00;
        for (int n = 0; n < 600; n++) begin
            flip = ($urandom_range(0, 2) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
            i = i ^ flip;
            ready = ($urandom_range(0, 2) != 0);
            ovf_clr = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
